shift_sequencer: RTL

Command-driven controller that sits directly upstream of the 4-bit universal/bidirectional shift register and drives its control inputs. It accepts one command per handshake: load a word, then apply N shift steps in a chosen direction, using either a constant fill bit or rotate. It also keeps a shadow copy of the register contents so the expected register value is visible at any cycle.

---
 rtl/shift_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Command sequencer for a universal shift register: loads a word, then issues
// N fill/rotate shift steps while tracking the register contents in a shadow copy.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic             cmd_mode,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             load_en,
    output logic             shift_en,
    output logic             sel,
    output logic             in,
    output logic [WIDTH-1:0] in_load,
    output logic [WIDTH-1:0] shadow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_mode;
    logic             r_fill;
    logic [CNT_W-1:0] r_cnt_cmd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_load_en;
    logic             r_shift_en;
    logic             r_in;

    logic [WIDTH-1:0] w_shifted;
    logic             w_first_in;
    logic             w_next_in;

    // The serial bit is registered, so it is derived from the value the shadow
    // will hold after this edge (the loaded word, or the word after this shift).
    assign w_shifted  = r_dir ? {r_in, r_shadow[WIDTH-1:1]} : {r_shadow[WIDTH-2:0], r_in};
    assign w_first_in = r_mode ? (r_dir ? r_data[0] : r_data[WIDTH-1]) : r_fill;
    assign w_next_in  = r_mode ? (r_dir ? w_shifted[0] : w_shifted[WIDTH-1]) : r_fill;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shadow   <= '0;
            r_data     <= '0;
            r_dir      <= 1'b0;
            r_mode     <= 1'b0;
            r_fill     <= 1'b0;
            r_cnt_cmd  <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_en  <= 1'b0;
            r_shift_en <= 1'b0;
            r_in       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data    <= cmd_data;
                        r_dir     <= cmd_dir;
                        r_mode    <= cmd_mode;
                        r_fill    <= cmd_fill;
                        r_cnt_cmd <= cmd_count;
                        r_state   <= S_LOAD;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_load_en <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_shadow  <= r_data;
                    r_cnt     <= r_cnt_cmd;
                    r_load_en <= 1'b0;
                    if (r_cnt_cmd != '0) begin
                        r_state    <= S_SHIFT;
                        r_shift_en <= 1'b1;
                        r_in       <= w_first_in;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_shadow <= w_shifted;
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state    <= S_DONE;
                        r_shift_en <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_in       <= 1'b0;
                    end else begin
                        r_in <= w_next_in;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign load_en  = r_load_en;
    assign shift_en = r_shift_en;
    assign sel      = r_dir;
    assign in       = r_in;
    assign in_load  = r_data;
    assign shadow   = r_shadow;

endmodule
